// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
// Purely declarative: no logic, no timing.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANTED,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  // Callers only ever pass idx < 2*n, so one conditional subtract is enough.
  function automatic int ptr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first set request scanning upward from ptr_i with wrap.
// Purely combinational, zero latency; no flow control of its own.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    // Scan from the far end so the candidate closest to ptr_i is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[ptr_wrap(int'(ptr_i) + i, N)]) begin
        idx_o = PTR_W'(ptr_wrap(int'(ptr_i) + i, N));
      end
    end
    any_o   = |req_i;
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Burst-locked round-robin sharing of one 8/N/1 UART transmitter among NUM_REQ byte streams.
// o_tx_start one cycle after handshake; o_ready only for the owner, only while GRANTED and transmitter idle.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MAX_BURST   = 16,
  parameter int HOLD_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] i_data,
  input  logic [NUM_REQ-1:0]        i_last,
  output logic [NUM_REQ-1:0]        o_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [BYTE_W-1:0]         o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_busy
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

  arb_state_t          state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [PTR_W-1:0]    owner_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [HCNT_W-1:0]   hcnt_q;
  logic [HCNT_W-1:0]   hcnt_d;
  logic                last_q;
  logic                tx_start_q;
  logic [BYTE_W-1:0]   tx_data_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic                handshake;
  logic [BYTE_W-1:0]   owner_data;
  logic [PTR_W-1:0]    ptr_next;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i   (i_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // grant_q is one-hot on the owner, so masking with it keeps non-owners at zero.
  assign o_ready    = (state_q == GRANTED && !i_tx_busy) ? (grant_q & i_valid) : '0;
  assign handshake  = |o_ready;
  assign owner_data = i_data[int'(owner_q)*BYTE_W +: BYTE_W];
  assign hcnt_d     = (hcnt_q == HCNT_W'(HOLD_CYCLES)) ? hcnt_q : hcnt_q + HCNT_W'(1);
  assign ptr_next   = PTR_W'(ptr_wrap(int'(owner_q) + 1, NUM_REQ));

  assign o_grant    = grant_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      bcnt_q     <= '0;
      hcnt_q     <= '0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_grant;
            owner_q <= pick_idx;
            bcnt_q  <= '0;
            hcnt_q  <= '0;
            state_q <= GRANTED;
          end
        end
        GRANTED: begin
          if (handshake) begin
            tx_data_q  <= owner_data;
            last_q     <= i_last[owner_q];
            bcnt_q     <= bcnt_q + BCNT_W'(1);
            hcnt_q     <= '0;
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end else begin
            hcnt_q <= hcnt_d;
            if (hcnt_d == HCNT_W'(HOLD_CYCLES)) begin
              grant_q <= '0;
              ptr_q   <= ptr_next;
              state_q <= IDLE;
            end
          end
        end
        LAUNCH: state_q <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (i_tx_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            if (last_q || bcnt_q == BCNT_W'(MAX_BURST)) begin
              grant_q <= '0;
              ptr_q   <= ptr_next;
              state_q <= IDLE;
            end else begin
              state_q <= GRANTED;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues, transaction-level
// round-robin model, and a monitor that checks every transmitter start plus invariants.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int MB = 4;
  localparam int HC = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   i_valid = '0;
  logic [8*N-1:0] i_data = '0;
  logic [N-1:0]   i_last = '0;
  logic [N-1:0]   o_ready;
  logic [N-1:0]   o_grant;
  logic [7:0]     o_tx_data;
  logic           o_tx_start;
  logic           i_tx_busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .MAX_BURST   (MB),
    .HOLD_CYCLES (HC)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_grant    (o_grant),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_busy  (i_tx_busy)
  );

  logic [8:0]  rbuf [N][64];
  int          rhead [N];
  int          rtail [N];
  int          busy_left = 0;
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          mptr = 0;

  task automatic clear_bufs();
    for (int k = 0; k < N; k++) begin
      rhead[k] = 0;
      rtail[k] = 0;
    end
  endtask

  task automatic load(input int k, input logic [7:0] d, input logic l);
    rbuf[k][rtail[k]] = {l, d};
    rtail[k]++;
  endtask

  // Transaction-level model: owners chosen round-robin among requesters with data;
  // an owner is served until its last byte, MAX_BURST bytes, or it runs dry.
  task automatic model_round();
    int h [N];
    int own;
    int cnt;
    logic [8:0] e;
    for (int k = 0; k < N; k++) h[k] = rhead[k];
    forever begin
      own = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (mptr + i) % N;
        if (own < 0 && h[k] < rtail[k]) own = k;
      end
      if (own < 0) break;
      cnt = 0;
      forever begin
        e = rbuf[own][h[own]];
        h[own]++;
        cnt++;
        exp_q.push_back({8'(own), e[7:0]});
        if (e[8] || cnt == MB || h[own] >= rtail[own]) break;
      end
      mptr = (own + 1) % N;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d bytes still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (20) @(negedge clk);
    checks++;
    if (o_grant != '0) begin
      errors++;
      $display("FAIL idle_after_drain: o_grant=%b, expected 0", o_grant);
    end
  endtask

  // Requester drivers and transmitter model; all inputs change 1 time unit after posedge.
  initial begin : drv
    logic [N-1:0] hs;
    logic st;
    forever begin
      @(negedge clk);
      hs = o_ready & i_valid;
      st = o_tx_start;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (hs[k]) rhead[k]++;
        if (rhead[k] < rtail[k]) begin
          i_valid[k] = 1'b1;
          {i_last[k], i_data[8*k +: 8]} = rbuf[k][rhead[k]];
        end else begin
          i_valid[k] = 1'b0;
          i_last[k]  = 1'b0;
        end
      end
      if (st) begin
        busy_left = $urandom_range(2, 12);
        i_tx_busy = 1'b1;
      end else if (busy_left > 1) begin
        busy_left--;
      end else begin
        busy_left = 0;
        i_tx_busy = 1'b0;
      end
    end
  end

  initial begin : mon
    logic prev_st;
    logic [15:0] e;
    logic [N-1:0] eg;
    prev_st = 1'b0;
    forever begin
      @(negedge clk);
      checks++;
      if (!$onehot0(o_grant)) begin
        errors++;
        $display("FAIL grant_onehot: o_grant=%b, expected one-hot or zero", o_grant);
      end
      checks++;
      if (o_tx_start && prev_st) begin
        errors++;
        $display("FAIL start_pulse: o_tx_start=1 two cycles running, expected single pulse");
      end
      checks++;
      if ((o_ready & ~o_grant) != '0) begin
        errors++;
        $display("FAIL ready_owner: o_ready=%b o_grant=%b, expected ready only for owner", o_ready, o_grant);
      end
      if (o_tx_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: data=%h grant=%b, expected no transmission", o_tx_data, o_grant);
        end else begin
          e = exp_q.pop_front();
          eg = '0;
          eg[int'(e[15:8])] = 1'b1;
          if (o_tx_data != e[7:0]) begin
            errors++;
            $display("FAIL tx_data: got %h, expected %h (req %0d)", o_tx_data, e[7:0], e[15:8]);
          end
          checks++;
          if (o_grant != eg) begin
            errors++;
            $display("FAIL tx_owner: o_grant=%b, expected %b", o_grant, eg);
          end
        end
      end
      prev_st = o_tx_start;
    end
  end

  initial begin : main
    int n;
    int cnt;
    int nb;
    int len;
    clear_bufs();
    repeat (3) @(negedge clk);
    checks += 3;
    if (o_grant != '0) begin errors++; $display("FAIL reset_grant: %b, expected 0", o_grant); end
    if (o_tx_start != 1'b0) begin errors++; $display("FAIL reset_start: %b, expected 0", o_tx_start); end
    if (o_tx_data != 8'h00) begin errors++; $display("FAIL reset_data: %h, expected 00", o_tx_data); end
    rst_n = 1'b1;
    @(negedge clk);

    clear_bufs(); load(0, 8'h55, 1'b1); model_round(); drain(2000);

    clear_bufs();
    for (int i = 0; i < 4; i++) begin
      load(0, 8'hA0, 1'b1);
      load(1, 8'hB1, 1'b1);
    end
    model_round(); drain(3000);

    clear_bufs();
    for (int i = 1; i <= 4; i++) load(1, 8'(i), i == 4);
    for (int i = 0; i < 4; i++) load(0, 8'h70 + 8'(i), 1'b1);
    model_round(); drain(3000);

    clear_bufs();
    for (int i = 1; i <= 6; i++) load(0, 8'h10 + 8'(i), i == 6);
    load(1, 8'h2B, 1'b1);
    model_round(); drain(3000);

    for (int r = 0; r < 6; r++) begin
      clear_bufs();
      for (int k = 0; k < N; k++) begin
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
          len = $urandom_range(1, 6);
          for (int j = 0; j < len; j++) load(k, 8'($urandom), j == len - 1);
        end
      end
      model_round(); drain(4000);
    end

    // Abort a byte in flight, then confirm arbitration restarts from requester 0.
    clear_bufs(); load(2, 8'hE7, 1'b1); model_round();
    n = 0;
    while (!i_tx_busy && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (o_grant != '0) begin errors++; $display("FAIL rst_grant: %b, expected 0", o_grant); end
    if (o_tx_start != 1'b0) begin errors++; $display("FAIL rst_start: %b, expected 0", o_tx_start); end
    if (o_tx_data != 8'h00) begin errors++; $display("FAIL rst_data: %h, expected 00", o_tx_data); end
    clear_bufs();
    exp_q.delete();
    busy_left = 0;
    i_tx_busy = 1'b0;
    mptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_bufs(); load(2, 8'h92, 1'b1); load(1, 8'h81, 1'b1); model_round(); drain(2000);

    clear_bufs(); load(0, 8'h3C, 1'b0); load(1, 8'hC3, 1'b1); model_round();
    n = 0;
    while (!(o_grant[0] && i_tx_busy) && n < 500) begin @(negedge clk); n++; end
    cnt = 0;
    n = 0;
    while (o_grant[0] && n < 500) begin
      if (!i_tx_busy) cnt++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (cnt != HC + 1) begin
      errors++;
      $display("FAIL hold_timeout: owner kept grant %0d idle cycles, expected %0d", cnt, HC + 1);
    end
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
